// File: rtl/cordic_arb_if.sv
// Bundle between requesters, the cordic_arb sequencer and the shared cordic engine.
// Requests are levels: i_req[k] is held with i_theta slice k stable until o_ack[k] or
// o_err for that requester; o_ack/o_err are one-cycle pulses; o_eng_req is a level the
// engine must see low for at least one edge between jobs.
interface cordic_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    i_req;
  logic [18*N_REQ-1:0] i_theta;
  logic [N_REQ-1:0]    o_gnt;
  logic [N_REQ-1:0]    o_ack;
  logic [17:0]         o_sin;
  logic [17:0]         o_cos;
  logic                o_err;
  logic                o_busy;
  logic                o_eng_req;
  logic [17:0]         o_eng_theta;
  logic [17:0]         i_eng_sin;
  logic [17:0]         i_eng_cos;
  logic                i_eng_ack;
  logic                dbg_state;
  logic [4:0]          dbg_cyc;

  modport slave (
    input  i_req, i_theta, i_eng_sin, i_eng_cos, i_eng_ack,
    output o_gnt, o_ack, o_sin, o_cos, o_err, o_busy, o_eng_req, o_eng_theta,
    output dbg_state, dbg_cyc
  );

  modport master (
    output i_req, i_theta, i_eng_sin, i_eng_cos, i_eng_ack,
    input  o_gnt, o_ack, o_sin, o_cos, o_err, o_busy, o_eng_req, o_eng_theta,
    input  dbg_state, dbg_cyc
  );
endinterface

// File: rtl/cordic_arb.sv
// Round-robin arbiter/sequencer sharing one cordic sin/cos engine between N_REQ
// requesters; qualifies the engine ack with its own cycle count and enforces a timeout.
module cordic_arb #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 17,
  parameter int TIMEOUT = 24
) (
  input logic        i_clk,
  input logic        i_nrst,
  cordic_arb_if.slave bus
);

  localparam int          PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0]  LAT_C   = 5'(LATENCY);
  localparam logic [4:0]  TO_C    = 5'(TIMEOUT);
  localparam logic [4:0]  CYC_MAX = 5'h1f;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [4:0]       cyc;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic [17:0]      sin_q;
  logic [17:0]      cos_q;
  logic             err_q;
  logic             busy_q;
  logic             eng_req_q;
  logic [17:0]      eng_theta_q;

  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic [PW-1:0]    cand_idx;
  int               cand;

  // Round-robin search starting one past the last winner, so the last winner ranks last.
  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(ptr) + i) % N_REQ;
      cand_idx = PW'(cand);
      if (!win_vld && bus.i_req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= S_IDLE;
      ptr         <= PW'(N_REQ - 1);
      cyc         <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_req_q   <= 1'b0;
      eng_theta_q <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          eng_req_q <= 1'b0;
          if (win_vld) begin
            gnt_q       <= N_REQ'(1) << win_idx;
            ptr         <= win_idx;
            eng_theta_q <= bus.i_theta[18*win_idx +: 18];
            eng_req_q   <= 1'b1;
            cyc         <= '0;
            busy_q      <= 1'b1;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (cyc != CYC_MAX) cyc <= cyc + 5'd1;
          // An ack before LATENCY is left over from a previous job and is ignored.
          if ((cyc == LAT_C) && bus.i_eng_ack) begin
            if (bus.i_req[ptr]) begin
              sin_q <= bus.i_eng_sin;
              cos_q <= bus.i_eng_cos;
              ack_q <= gnt_q;
            end
            gnt_q     <= '0;
            eng_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end else if (cyc == TO_C) begin
            err_q     <= 1'b1;
            gnt_q     <= '0;
            eng_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          gnt_q     <= '0;
          eng_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_ack       = ack_q;
  assign bus.o_sin       = sin_q;
  assign bus.o_cos       = cos_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_eng_req   = eng_req_q;
  assign bus.o_eng_theta = eng_theta_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_cyc     = cyc;

endmodule
